// File: rtl/plab2_mem_blocking_cache_pkg.sv
// plab2_mem_blocking_cache_pkg: vc mem message layouts, type codes and cache FSM state encodings
package plab2_mem_blocking_cache_pkg;
  localparam int REQ_NBITS = 77;
  localparam int RESP_NBITS = 45;
  localparam logic [2:0] TYPE_READ = 3'd0;
  localparam logic [2:0] TYPE_WRITE = 3'd1;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] TC = 3'd1;
  localparam logic [2:0] RD_REQ = 3'd2;
  localparam logic [2:0] RD_WAIT = 3'd3;
  localparam logic [2:0] WR_REQ = 3'd4;
  localparam logic [2:0] WR_WAIT = 3'd5;
  localparam logic [2:0] RESP = 3'd6;
  typedef struct packed {
    logic [2:0] typ;
    logic [7:0] opaque;
    logic [31:0] addr;
    logic [1:0] len;
    logic [31:0] data;
  } mem_req_t;
  typedef struct packed {
    logic [2:0] typ;
    logic [7:0] opaque;
    logic [1:0] len;
    logic [31:0] data;
  } mem_resp_t;
  function automatic int tag_bits(input int num_lines);
    return 30 - $clog2(num_lines);
  endfunction
endpackage

// File: rtl/plab2_mem_cache_array.sv
// plab2_mem_cache_array: valid/tag/data line arrays; ports clk, reset, idx, wen/wtag/wdata in, valid/tag/data combinational read out
module plab2_mem_cache_array #(
  parameter int NUM_LINES = 16,
  parameter int TW = 26
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(NUM_LINES)-1:0] idx,
  input  logic                         wen,
  input  logic [TW-1:0]                wtag,
  input  logic [31:0]                  wdata,
  output logic                         valid,
  output logic [TW-1:0]                tag,
  output logic [31:0]                  data
);
  logic [NUM_LINES-1:0] valids;
  logic [TW-1:0] tags [NUM_LINES];
  logic [31:0] words [NUM_LINES];
  assign valid = valids[idx];
  assign tag = tags[idx];
  assign data = words[idx];
  always_ff @(posedge clk) begin
    if (reset) valids <= '0;
    else if (wen) valids[idx] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (wen) begin
      tags[idx] <= wtag;
      words[idx] <= wdata;
    end
  end
endmodule

// File: rtl/plab2_mem_blocking_cache.sv
// plab2_mem_blocking_cache: direct-mapped blocking write-through no-write-allocate cache; cachereq/cacheresp to processor, memreq/memresp to memory
module plab2_mem_blocking_cache
  import plab2_mem_blocking_cache_pkg::*;
#(
  parameter int NUM_LINES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REQ_NBITS-1:0]  cachereq_msg,
  input  logic                  cachereq_val,
  output logic                  cachereq_rdy,
  output logic [RESP_NBITS-1:0] cacheresp_msg,
  output logic                  cacheresp_val,
  input  logic                  cacheresp_rdy,
  output logic [REQ_NBITS-1:0]  memreq_msg,
  output logic                  memreq_val,
  input  logic                  memreq_rdy,
  input  logic [RESP_NBITS-1:0] memresp_msg,
  input  logic                  memresp_val,
  output logic                  memresp_rdy
);
  localparam int IDX = $clog2(NUM_LINES);
  localparam int TW = tag_bits(NUM_LINES);
  logic [2:0] state, state_nxt;
  mem_req_t req;
  mem_resp_t mresp;
  logic [31:0] resp_data;
  logic [IDX-1:0] idx;
  logic [TW-1:0] tag, arr_tag;
  logic [31:0] arr_data;
  logic arr_valid, arr_wen, hit, is_wr, fill, unused_ok;
  assign mresp = memresp_msg;
  assign idx = req.addr[IDX+1:2];
  assign tag = req.addr[31:IDX+2];
  assign is_wr = req.typ == TYPE_WRITE;
  assign hit = arr_valid && arr_tag == tag;
  assign fill = state == RD_WAIT && memresp_val && memresp_rdy;
  assign arr_wen = (state == TC && is_wr && hit) || fill;
  assign unused_ok = &{1'b0, mresp.typ, mresp.opaque, mresp.len, req.len, req.addr[1:0]};
  plab2_mem_cache_array #(.NUM_LINES(NUM_LINES), .TW(TW)) array (
    .clk   (clk),
    .reset (reset),
    .idx   (idx),
    .wen   (arr_wen),
    .wtag  (tag),
    .wdata (state == TC ? req.data : mresp.data),
    .valid (arr_valid),
    .tag   (arr_tag),
    .data  (arr_data)
  );
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cachereq_val) state_nxt = TC;
      TC:      state_nxt = is_wr ? WR_REQ : hit ? RESP : RD_REQ;
      RD_REQ:  if (memreq_rdy) state_nxt = RD_WAIT;
      RD_WAIT: if (memresp_val) state_nxt = RESP;
      WR_REQ:  if (memreq_rdy) state_nxt = WR_WAIT;
      WR_WAIT: if (memresp_val) state_nxt = RESP;
      RESP:    if (cacheresp_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : state_nxt;
    if (cachereq_val && cachereq_rdy) req <= cachereq_msg;
    if (state == TC) resp_data <= is_wr ? 32'h0 : arr_data;
    if (fill) resp_data <= mresp.data;
  end
  assign cachereq_rdy = !reset && state == IDLE;
  assign memreq_val = !reset && (state == RD_REQ || state == WR_REQ);
  assign memresp_rdy = !reset && (state == RD_WAIT || state == WR_WAIT);
  assign cacheresp_val = !reset && state == RESP;
  assign memreq_msg = {req.typ, 8'h0, req.addr, 2'b00, is_wr ? req.data : 32'h0};
  assign cacheresp_msg = {req.typ, req.opaque, 2'b00, resp_data};
endmodule

// File: tb/tb_plab2_mem_blocking_cache.sv
// tb_plab2_mem_blocking_cache: randomized check of the blocking cache against a tag/valid + memory reference model
module tb_plab2_mem_blocking_cache;
  import plab2_mem_blocking_cache_pkg::*;
  logic clk = 0;
  logic reset = 1;
  logic [76:0] cachereq_msg = '0;
  logic cachereq_val = 0;
  logic cachereq_rdy;
  logic [44:0] cacheresp_msg;
  logic cacheresp_val;
  logic cacheresp_rdy = 0;
  logic [76:0] memreq_msg;
  logic memreq_val;
  logic memreq_rdy = 0;
  logic [44:0] memresp_msg = '0;
  logic memresp_val = 0;
  logic memresp_rdy;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] mem [0:4095];
  bit mv [16];
  logic [25:0] mt [16];
  always #5 clk = ~clk;
  plab2_mem_blocking_cache #(.NUM_LINES(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .cachereq_msg  (cachereq_msg),
    .cachereq_val  (cachereq_val),
    .cachereq_rdy  (cachereq_rdy),
    .cacheresp_msg (cacheresp_msg),
    .cacheresp_val (cacheresp_val),
    .cacheresp_rdy (cacheresp_rdy),
    .memreq_msg    (memreq_msg),
    .memreq_val    (memreq_val),
    .memreq_rdy    (memreq_rdy),
    .memresp_msg   (memresp_msg),
    .memresp_val   (memresp_val),
    .memresp_rdy   (memresp_rdy)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [7:0] op,
                     input int cr_stall, input int mq_stall, input int ms_delay);
    int i, cyc, nmreq, mq_wait, cr_wait, ms_cnt, first;
    bit hit, done, acc;
    logic [31:0] exp_d, mdat;
    logic [2:0] mtyp;
    logic [76:0] mq_hold;
    logic [44:0] cr_hold;
    mem_req_t mq;
    mem_resp_t cr;
    i = int'(a[5:2]);
    hit = !wr && mv[i] && mt[i] == a[31:6];
    exp_d = wr ? 32'h0 : mem[a[13:2]];
    mtyp = TYPE_READ;
    mdat = 32'h0;
    mq_hold = '0;
    cr_hold = '0;
    cachereq_msg = {wr ? TYPE_WRITE : TYPE_READ, op, a, 2'b00, wd};
    cachereq_val = 1;
    cyc = 0;
    while (!cachereq_rdy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("req_rdy", cachereq_rdy, 1);
    @(negedge clk);
    cachereq_val = 0;
    cyc = 1; nmreq = 0; mq_wait = 0; cr_wait = 0; ms_cnt = -1; first = 0; done = 0; acc = 0;
    while (!done && cyc < 200) begin
      if (memresp_val && acc) memresp_val = 0;
      acc = 0;
      if (ms_cnt > 0) ms_cnt--;
      else if (ms_cnt == 0) begin
        memresp_msg = {mtyp, 8'h0, 2'b00, mdat};
        memresp_val = 1;
        ms_cnt = -1;
      end
      if (memresp_val) acc = memresp_rdy;
      memreq_rdy = 0;
      if (memreq_val) begin
        mq = memreq_msg;
        if (mq_wait == 0) mq_hold = memreq_msg;
        else chk("mreq_stable", memreq_msg, mq_hold);
        if (mq_wait < mq_stall) mq_wait++;
        else begin
          memreq_rdy = 1;
          nmreq++;
          mq_wait = 0;
          chk("mreq_type", mq.typ, wr ? TYPE_WRITE : TYPE_READ);
          chk("mreq_addr", mq.addr, a);
          chk("mreq_len", mq.len, 0);
          if (wr) begin
            chk("mreq_data", mq.data, wd);
            mem[a[13:2]] = wd;
          end else chk("mreq_opaque", mq.opaque, 0);
          mtyp = mq.typ;
          mdat = wr ? 32'h0 : mem[mq.addr[13:2]];
          ms_cnt = ms_delay;
        end
      end
      cacheresp_rdy = 0;
      if (cacheresp_val) begin
        cr = cacheresp_msg;
        if (first == 0) begin
          first = cyc;
          cr_hold = cacheresp_msg;
        end else chk("cresp_stable", cacheresp_msg, cr_hold);
        chk("req_rdy_busy", cachereq_rdy, 0);
        if (cr_wait < cr_stall) cr_wait++;
        else begin
          cacheresp_rdy = 1;
          done = 1;
          chk("cresp_type", cr.typ, wr ? TYPE_WRITE : TYPE_READ);
          chk("cresp_opaque", cr.opaque, op);
          chk("cresp_len", cr.len, 0);
          chk("cresp_data", cr.data, exp_d);
        end
      end
      @(negedge clk);
      cyc++;
    end
    cacheresp_rdy = 0;
    memreq_rdy = 0;
    memresp_val = 0;
    chk("done", done, 1);
    chk("nmreq", nmreq, hit ? 0 : 1);
    if (hit) chk("hit_lat", first, 2);
    chk("idle_rdy", cachereq_rdy, 1);
    if (!wr && !hit) begin
      mv[i] = 1;
      mt[i] = a[31:6];
    end
  endtask
  initial begin
    logic [31:0] a;
    for (int k = 0; k < 4096; k++) mem[k] = $urandom;
    for (int k = 0; k < 16; k++) mv[k] = 0;
    repeat (2) @(negedge clk);
    chk("rst_cresp_val", cacheresp_val, 0);
    chk("rst_mreq_val", memreq_val, 0);
    chk("rst_mresp_rdy", memresp_rdy, 0);
    reset = 0;
    @(negedge clk);
    chk("post_rst_req_rdy", cachereq_rdy, 1);
    chk("post_rst_cresp_val", cacheresp_val, 0);
    chk("post_rst_mreq_val", memreq_val, 0);
    chk("post_rst_mresp_rdy", memresp_rdy, 0);
    mem[32'h1000 >> 2] = 32'hdeadbeef;
    txn(0, 32'h1000, 0, 8'h5a, 0, 0, 1);
    txn(0, 32'h1000, 0, 8'h5b, 0, 0, 0);
    txn(1, 32'h1000, 32'hcafe0000, 8'h11, 0, 0, 2);
    txn(0, 32'h1000, 0, 8'h12, 0, 0, 0);
    chk("wr_through_mem", mem[32'h1000 >> 2], 32'hcafe0000);
    txn(0, 32'h1040, 0, 8'h13, 0, 0, 0);
    txn(0, 32'h1000, 0, 8'h14, 0, 0, 0);
    txn(1, 32'h2000, 32'h1, 8'h15, 0, 0, 0);
    txn(0, 32'h2000, 0, 8'h16, 0, 0, 1);
    txn(0, 32'h2000, 0, 8'h17, 5, 0, 0);
    txn(0, 32'h2044, 0, 8'h18, 5, 5, 3);
    txn(1, 32'h2044, 32'h77, 8'h19, 2, 5, 0);
    cachereq_msg = {TYPE_READ, 8'h21, 32'h3008, 2'b00, 32'h0};
    cachereq_val = 1;
    @(negedge clk);
    cachereq_val = 0;
    @(negedge clk);
    chk("rst_mid_mreq_val", memreq_val, 1);
    memreq_rdy = 1;
    @(negedge clk);
    memreq_rdy = 0;
    chk("rst_mid_mresp_rdy", memresp_rdy, 1);
    reset = 1;
    #1;
    chk("rst_mid_cresp_val", cacheresp_val, 0);
    chk("rst_mid_mresp_rdy_gated", memresp_rdy, 0);
    @(negedge clk);
    reset = 0;
    #1;
    chk("rst_mid_idle", cachereq_rdy, 1);
    for (int k = 0; k < 16; k++) mv[k] = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_no_resp", cacheresp_val, 0);
    end
    txn(0, 32'h1000, 0, 8'h22, 0, 0, 0);
    txn(0, 32'h2044, 0, 8'h23, 0, 0, 0);
    for (int n = 0; n < 150; n++) begin
      a = 32'h1000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 15) << 2);
      txn($urandom_range(0, 3) == 0, a, $urandom, 8'($urandom), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
